// File: rtl/oup_hex_pkg.sv
// Shared definitions for the HEX0-HEX5 display slave: register map, CTRL field
// positions and the seven-segment glyph table.
package oup_hex_pkg;

    typedef logic [7:0] seg_t;

    localparam int NUM_DIGITS = 6;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_VALUE  = 3'd1;
    localparam logic [2:0] REG_RAW_LO = 3'd2;
    localparam logic [2:0] REG_RAW_HI = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_RAW_BIT   = 1;
    localparam int CTRL_BLINK_LSB = 8;
    localparam int CTRL_DP_LSB    = 16;

    localparam logic [31:0] CTRL_MASK = 32'h003F_3F03;

    // Active-high {dp,g,f,e,d,c,b,a}; dp is always off here.
    function automatic seg_t hex_seg(input logic [3:0] nib);
        seg_t s;
        case (nib)
            4'h0: s = 8'h3F;
            4'h1: s = 8'h06;
            4'h2: s = 8'h5B;
            4'h3: s = 8'h4F;
            4'h4: s = 8'h66;
            4'h5: s = 8'h6D;
            4'h6: s = 8'h7D;
            4'h7: s = 8'h07;
            4'h8: s = 8'h7F;
            4'h9: s = 8'h6F;
            4'hA: s = 8'h77;
            4'hB: s = 8'h7C;
            4'hC: s = 8'h39;
            4'hD: s = 8'h5E;
            4'hE: s = 8'h79;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/oup_hex_display_if.sv
// Wishbone classic bus bundle between the NEORV32 external bus and the display slave.
interface oup_hex_display_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/oup_hex_decode.sv
// Combinational nibble to seven-segment glyph (active-high, dp clear).
module oup_hex_decode
    import oup_hex_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg_t       seg_o
);
    assign seg_o = hex_seg(nib_i);
endmodule

// File: rtl/oup_hex_display.sv
// Wishbone classic slave driving the six DE10-Lite seven-segment displays with
// hex/raw modes, per-digit blink and decimal-point masks, active-low outputs.
module oup_hex_display
    import oup_hex_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BLINK_HZ = 2
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_i,
    oup_hex_display_if.slave     wb,
    output logic [5:0][7:0]      hex_o
);
    localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
    localparam int CNT_W = $clog2(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    logic [31:0]      ctrl_q, ctrl_d;
    logic [23:0]      value_q, value_d;
    logic [31:0]      raw_lo_q, raw_lo_d;
    logic [15:0]      raw_hi_q, raw_hi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic [31:0]      dat_q, dat_d;
    logic [5:0][7:0]  hex_q, hex_d;

    seg_t [5:0]       glyph;
    logic [47:0]      raw_all;
    logic [2:0]       idx;
    logic             req;
    logic [31:0]      rdata;
    logic             adr_unused;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dec
        oup_hex_decode u_dec (
            .nib_i (value_q[4*d +: 4]),
            .seg_o (glyph[d])
        );
    end

    assign idx        = wb.wb_adr_i[4:2];
    assign adr_unused = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0]};
    assign req        = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
    assign raw_all    = {raw_hi_q, raw_lo_q};

    always_comb begin
        rdata = 32'h0;
        case (idx)
            REG_CTRL:   rdata = ctrl_q;
            REG_VALUE:  rdata = {8'h00, value_q};
            REG_RAW_LO: rdata = raw_lo_q;
            REG_RAW_HI: rdata = {16'h0000, raw_hi_q};
            REG_STATUS: rdata = {31'h0, phase_q};
            default:    rdata = 32'h0;
        endcase
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        value_d  = value_q;
        raw_lo_d = raw_lo_q;
        raw_hi_d = raw_hi_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = 32'h0;
        phase_d  = phase_q;
        cnt_d    = cnt_q + 1'b1;

        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end

        if (req) begin
            if (idx <= REG_STATUS) begin
                ack_d = 1'b1;
                if (wb.wb_we_i) begin
                    case (idx)
                        REG_CTRL:   ctrl_d   = merge_lanes(ctrl_q, wb.wb_dat_i, wb.wb_sel_i) & CTRL_MASK;
                        REG_VALUE:  value_d  = merge_lanes({8'h00, value_q}, wb.wb_dat_i, wb.wb_sel_i) & 32'h00FF_FFFF;
                        REG_RAW_LO: raw_lo_d = merge_lanes(raw_lo_q, wb.wb_dat_i, wb.wb_sel_i);
                        REG_RAW_HI: raw_hi_d = merge_lanes({16'h0000, raw_hi_q}, wb.wb_dat_i, wb.wb_sel_i) & 32'h0000_FFFF;
                        default: ;
                    endcase
                end else begin
                    dat_d = rdata;
                end
            end else begin
                err_d = 1'b1;
            end
        end

        // Segment outputs are built from the registered state, so they trail a write by one cycle.
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (ctrl_q[CTRL_RAW_BIT]) begin
                hex_d[d] = ~raw_all[8*d +: 8];
            end else begin
                hex_d[d] = ~{ctrl_q[CTRL_DP_LSB + d], glyph[d][6:0]};
            end
            if (!ctrl_q[CTRL_EN_BIT] || (ctrl_q[CTRL_BLINK_LSB + d] && phase_q)) begin
                hex_d[d] = 8'hFF;
            end
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            ctrl_q   <= '0;
            value_q  <= '0;
            raw_lo_q <= '0;
            raw_hi_q <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
            hex_q    <= {NUM_DIGITS{8'hFF}};
        end else begin
            ctrl_q   <= ctrl_d;
            value_q  <= value_d;
            raw_lo_q <= raw_lo_d;
            raw_hi_q <= raw_hi_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            dat_q    <= dat_d;
            hex_q    <= hex_d;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = dat_q;
    assign hex_o       = hex_q;

endmodule

// File: tb/tb_oup_hex_display.sv
// Directed bench for oup_hex_display with a 16-cycle blink period (HALF = 8).
module tb_oup_hex_display;

    logic clk = 1'b0;
    logic rst;
    logic [5:0][7:0] hex;

    always #5 clk = ~clk;

    oup_hex_display_if bus ();

    oup_hex_display #(.CLK_HZ(32), .BLINK_HZ(2)) dut (
        .clk_sys_i (clk),
        .rst_i     (rst),
        .wb        (bus.slave),
        .hex_o     (hex)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic we, input logic [2:0] idx, input logic [3:0] sel,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic acked, output logic erred);
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = 32'h8000_0000 | {27'h0, idx, 2'b00};
        bus.wb_sel_i = sel;
        bus.wb_dat_i = wdata;
        acked = 1'b0;
        erred = 1'b0;
        rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.wb_ack_o || bus.wb_err_o) begin
                acked = bus.wb_ack_o;
                erred = bus.wb_err_o;
                rdata = bus.wb_dat_o;
                break;
            end
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] idx, input logic [3:0] sel, input logic [31:0] data);
        logic [31:0] rd_v;
        logic a, e;
        xfer(1'b1, idx, sel, data, rd_v, a, e);
        check($sformatf("wr_ack_idx%0d", idx), {31'h0, a}, 32'h1);
    endtask

    task automatic rd(input logic [2:0] idx, output logic [31:0] data);
        logic a, e;
        xfer(1'b0, idx, 4'hF, 32'h0, data, a, e);
        check($sformatf("rd_ack_idx%0d", idx), {31'h0, a}, 32'h1);
    endtask

    initial begin
        logic [31:0] d;
        logic a, e;
        logic found;
        int   idx_seq [5];

        rst = 1'b1;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 32'h0;
        bus.wb_sel_i = 4'h0;
        bus.wb_dat_i = 32'h0;

        // Reset state
        repeat (3) tick();
        for (int i = 0; i < 6; i++) check($sformatf("rst_hex%0d", i), {24'h0, hex[i]}, 32'hFF);
        check("rst_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        check("rst_err", {31'h0, bus.wb_err_o}, 32'h0);
        check("rst_dat", bus.wb_dat_o, 32'h0);
        rst = 1'b0;
        idx_seq = '{4, 0, 1, 2, 3};
        for (int i = 0; i < 5; i++) begin
            rd(3'(idx_seq[i]), d);
            check($sformatf("rst_rd_idx%0d", idx_seq[i]), d, 32'h0);
        end

        // Hex decode
        wr(3'd0, 4'hF, 32'h0000_0001);
        wr(3'd1, 4'hF, 32'h0000_A5C3);
        tick();
        check("hex0_3", {24'h0, hex[0]}, {24'h0, ~8'h4F});
        check("hex1_C", {24'h0, hex[1]}, {24'h0, ~8'h39});
        check("hex2_5", {24'h0, hex[2]}, {24'h0, ~8'h6D});
        check("hex3_A", {24'h0, hex[3]}, {24'h0, ~8'h77});
        check("hex4_0", {24'h0, hex[4]}, {24'h0, ~8'h3F});
        check("hex5_0", {24'h0, hex[5]}, {24'h0, ~8'h3F});
        rd(3'd1, d);
        check("value_rb", d, 32'h0000_A5C3);

        // Decimal point on digit 0
        wr(3'd0, 4'hF, 32'h0001_0001);
        tick();
        check("hex0_dp", {24'h0, hex[0]}, {24'h0, ~8'hCF});
        check("hex1_nodp", {24'h0, hex[1]}, {24'h0, ~8'h39});

        // Byte lanes and raw mode
        wr(3'd0, 4'hF, 32'h0);
        wr(3'd2, 4'b0100, 32'hFFFF_FFFF);
        rd(3'd2, d);
        check("rawlo_lane2", d, 32'h00FF_0000);
        wr(3'd0, 4'hF, 32'h0000_0003);
        tick();
        for (int i = 0; i < 6; i++)
            check($sformatf("raw_hex%0d", i), {24'h0, hex[i]}, (i == 2) ? 32'h00 : 32'hFF);

        // Blink on digit 0: sync to a lit -> blank transition, then walk one period
        wr(3'd0, 4'hF, 32'h0000_0101);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (hex[0] == 8'hB0) found = 1'b1;
        end
        check("blink_lit_seen", {31'h0, found}, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (hex[0] == 8'hFF) found = 1'b1;
        end
        check("blink_blank_seen", {31'h0, found}, 32'h1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("blink_hex0_c%0d", i), {24'h0, hex[0]}, (i < 8) ? 32'hFF : 32'hB0);
            check($sformatf("blink_hex1_c%0d", i), {24'h0, hex[1]}, 32'hC6);
            if (i != 15) tick();
        end
        // Reads land every second cycle; phase stays 1 for four reads then 0
        for (int k = 0; k < 8; k++) begin
            rd(3'd4, d);
            check($sformatf("status_phase_r%0d", k), d, (k < 4) ? 32'h1 : 32'h0);
        end

        // Unmapped accesses
        xfer(1'b0, 3'd6, 4'hF, 32'h0, d, a, e);
        check("err6_err", {31'h0, e}, 32'h1);
        check("err6_ack", {31'h0, a}, 32'h0);
        check("err6_dat", d, 32'h0);
        xfer(1'b1, 3'd7, 4'hF, 32'hFFFF_FFFF, d, a, e);
        check("err7_err", {31'h0, e}, 32'h1);
        check("err7_ack", {31'h0, a}, 32'h0);
        rd(3'd0, d);  check("err7_ctrl", d, 32'h0000_0101);
        rd(3'd1, d);  check("err7_value", d, 32'h0000_A5C3);
        rd(3'd2, d);  check("err7_rawlo", d, 32'h00FF_0000);
        rd(3'd3, d);  check("err7_rawhi", d, 32'h0);

        // Held strobe: ack, idle, ack, idle, ...
        tick();
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 32'h0000_0004;
        bus.wb_sel_i = 4'hF;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("held_ack_c%0d", i + 1), {31'h0, bus.wb_ack_o}, (i % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("held_dat_c%0d", i + 1), bus.wb_dat_o, (i % 2 == 0) ? 32'h0000_A5C3 : 32'h0);
        end
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        tick();

        // Cycle aborted before any edge sees it
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = 32'h0000_0004;
        bus.wb_dat_i = 32'h0012_3456;
        #3;
        bus.wb_cyc_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("abort_ack_c%0d", i), {31'h0, bus.wb_ack_o}, 32'h0);
        end
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        rd(3'd1, d);
        check("abort_value", d, 32'h0000_A5C3);

        // Reset coinciding with a write
        tick();
        rst = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b1;
        bus.wb_adr_i = 32'h0000_000C;
        bus.wb_dat_i = 32'h0000_BEEF;
        tick();
        check("rstwr_ack", {31'h0, bus.wb_ack_o}, 32'h0);
        check("rstwr_hex0", {24'h0, hex[0]}, 32'hFF);
        rst = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        rd(3'd3, d);
        check("rstwr_rawhi", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
